// File: rtl/column_hamm_dec.sv
// rtl/column_hamm_dec.sv - column-address Hamming checker/corrector with one-deep output stage
// Syndrome decode corrects single-bit errors; saturating counters track corrected/uncorrectable words.
module column_hamm_dec #(
  parameter int MAX_COL = 40,
  parameter int CNT_W   = 16
) (
  input  logic             Clk,
  input  logic             Reset_b,
  input  logic             InValid,
  output logic             InReady,
  input  logic [9:0]       ColumnIn,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [5:0]       ColAddr,
  output logic             Corrected,
  output logic             Uncorrectable,
  output logic             RangeErr,
  input  logic             CntClear,
  output logic [CNT_W-1:0] CorrCnt,
  output logic [CNT_W-1:0] UncorrCnt
);

  localparam logic [5:0]       MAX_COL_V = 6'(MAX_COL);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  logic [5:0] rawAddr;
  logic [3:0] rxCheck;
  logic [3:0] calcCheck;
  logic [3:0] syndrome;
  logic [5:0] flipMask;
  logic [5:0] fixedAddr;
  logic       isCorr;
  logic       isUncorr;
  logic       isRange;
  logic       accept;

  assign rawAddr = ColumnIn[5:0];
  assign rxCheck = ColumnIn[9:6];

  assign calcCheck[0] = rawAddr[0] ^ rawAddr[1] ^ rawAddr[3] ^ rawAddr[4];
  assign calcCheck[1] = rawAddr[0] ^ rawAddr[2] ^ rawAddr[3] ^ rawAddr[5];
  assign calcCheck[2] = rawAddr[1] ^ rawAddr[2] ^ rawAddr[3];
  assign calcCheck[3] = rawAddr[4] ^ rawAddr[5];
  assign syndrome     = rxCheck ^ calcCheck;

  // Single-bit check-bit errors (1/2/4/8) leave the address alone but still count as corrected.
  always_comb begin
    flipMask = 6'b0;
    isCorr   = 1'b0;
    isUncorr = 1'b0;
    case (syndrome)
      4'd0:  ;
      4'd1, 4'd2, 4'd4, 4'd8: isCorr = 1'b1;
      4'd3:  begin flipMask = 6'b000001; isCorr = 1'b1; end
      4'd5:  begin flipMask = 6'b000010; isCorr = 1'b1; end
      4'd6:  begin flipMask = 6'b000100; isCorr = 1'b1; end
      4'd7:  begin flipMask = 6'b001000; isCorr = 1'b1; end
      4'd9:  begin flipMask = 6'b010000; isCorr = 1'b1; end
      4'd10: begin flipMask = 6'b100000; isCorr = 1'b1; end
      default: isUncorr = 1'b1;
    endcase
  end

  assign fixedAddr = rawAddr ^ flipMask;
  assign isRange   = (fixedAddr == 6'd0) || (fixedAddr > MAX_COL_V);
  assign InReady   = !OutValid || OutReady;
  assign accept    = InValid && InReady;

  always_ff @(posedge Clk or negedge Reset_b) begin
    if (!Reset_b) begin
      OutValid      <= 1'b0;
      ColAddr       <= 6'd0;
      Corrected     <= 1'b0;
      Uncorrectable <= 1'b0;
      RangeErr      <= 1'b0;
    end else if (InReady) begin
      OutValid <= InValid;
      if (InValid) begin
        ColAddr       <= fixedAddr;
        Corrected     <= isCorr;
        Uncorrectable <= isUncorr;
        RangeErr      <= isRange;
      end
    end
  end

  // Clear wins over a same-cycle increment, so the word accepted with CntClear is not counted.
  always_ff @(posedge Clk or negedge Reset_b) begin
    if (!Reset_b) begin
      CorrCnt   <= '0;
      UncorrCnt <= '0;
    end else if (CntClear) begin
      CorrCnt   <= '0;
      UncorrCnt <= '0;
    end else if (accept) begin
      if (isCorr && CorrCnt != CNT_MAX)
        CorrCnt <= CorrCnt + 1'b1;
      if (isUncorr && UncorrCnt != CNT_MAX)
        UncorrCnt <= UncorrCnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_column_hamm_dec.sv
// tb/tb_column_hamm_dec.sv - scoreboard bench for column_hamm_dec
// Directed codewords with hand-computed results; monitor pops expected outputs on each handshake.
module tb_column_hamm_dec;

  localparam int CNT_W = 2;

  typedef struct packed {
    logic [5:0] addr;
    logic       corr;
    logic       uncorr;
    logic       range;
  } exp_t;

  logic             Clk = 1'b0;
  logic             Reset_b = 1'b0;
  logic             InValid = 1'b0;
  logic             InReady;
  logic [9:0]       ColumnIn = 10'd0;
  logic             OutValid;
  logic             OutReady = 1'b1;
  logic [5:0]       ColAddr;
  logic             Corrected;
  logic             Uncorrectable;
  logic             RangeErr;
  logic             CntClear = 1'b0;
  logic [CNT_W-1:0] CorrCnt;
  logic [CNT_W-1:0] UncorrCnt;

  int   checks = 0;
  int   errors = 0;
  int   popped = 0;
  exp_t expQ[$];
  bit   streamDone;

  column_hamm_dec #(.MAX_COL(40), .CNT_W(CNT_W)) dut (
    .Clk(Clk), .Reset_b(Reset_b), .InValid(InValid), .InReady(InReady),
    .ColumnIn(ColumnIn), .OutValid(OutValid), .OutReady(OutReady),
    .ColAddr(ColAddr), .Corrected(Corrected), .Uncorrectable(Uncorrectable),
    .RangeErr(RangeErr), .CntClear(CntClear), .CorrCnt(CorrCnt), .UncorrCnt(UncorrCnt)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Monitor: handshake inputs settle 1 time unit after posedge, so the negedge sees the transfer.
  always @(negedge Clk) begin
    if (Reset_b && OutValid && OutReady) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got addr %0d expected no output", ColAddr);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        popped++;
        check("out_addr", int'(ColAddr), int'(e.addr));
        check("out_corr", int'(Corrected), int'(e.corr));
        check("out_uncorr", int'(Uncorrectable), int'(e.uncorr));
        check("out_range", int'(RangeErr), int'(e.range));
      end
    end
  end

  task automatic send(input logic [9:0] w, input logic [5:0] a, input logic c,
                      input logic u, input logic r);
    bit acc;
    int budget;
    exp_t e;
    e = '{addr: a, corr: c, uncorr: u, range: r};
    InValid  = 1'b1;
    ColumnIn = w;
    acc = 1'b0;
    budget = 0;
    while (!acc && budget < 60) begin
      @(negedge Clk);
      acc = InReady;
      @(posedge Clk);
      #1;
      budget++;
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got no accept expected accept of %0h", w);
    end else begin
      expQ.push_back(e);
    end
    InValid = 1'b0;
  endtask

  initial begin
    int wait_cyc;
    // Reset state
    #3;
    check("rst_outvalid", int'(OutValid), 0);
    check("rst_inready", int'(InReady), 1);
    check("rst_coladdr", int'(ColAddr), 0);
    check("rst_flags", int'({Corrected, Uncorrectable, RangeErr}), 0);
    check("rst_cnts", int'({CorrCnt, UncorrCnt}), 0);
    @(posedge Clk); #1;
    Reset_b = 1'b1;
    @(posedge Clk); #1;

    send(10'h315, 6'd21, 1'b0, 1'b0, 1'b0);
    @(posedge Clk); #1;
    check("clean_corrcnt", int'(CorrCnt), 0);
    check("clean_uncorrcnt", int'(UncorrCnt), 0);
    send(10'h31D, 6'd21, 1'b1, 1'b0, 1'b0);
    check("data_err_corrcnt", int'(CorrCnt), 1);
    send(10'h115, 6'd21, 1'b1, 1'b0, 1'b0);
    check("chk_err_corrcnt", int'(CorrCnt), 2);
    send(10'h30D, 6'd13, 1'b0, 1'b1, 1'b0);
    check("double_uncorrcnt", int'(UncorrCnt), 1);
    check("double_corrcnt", int'(CorrCnt), 2);
    send(10'h000, 6'd0,  1'b0, 1'b0, 1'b1);
    send(10'h3A9, 6'd41, 1'b0, 1'b0, 1'b1);
    send(10'h368, 6'd40, 1'b0, 1'b0, 1'b0);

    // Remaining single errors push the 2-bit counter into saturation
    send(10'h348, 6'd40, 1'b1, 1'b0, 1'b0);
    check("corrcnt_3", int'(CorrCnt), 3);
    send(10'h314, 6'd21, 1'b1, 1'b0, 1'b0);
    send(10'h355, 6'd21, 1'b1, 1'b0, 1'b0);
    check("corrcnt_sat", int'(CorrCnt), 3);

    CntClear = 1'b1;
    send(10'h314, 6'd21, 1'b1, 1'b0, 1'b0);
    CntClear = 1'b0;
    check("clear_corrcnt", int'(CorrCnt), 0);
    check("clear_uncorrcnt", int'(UncorrCnt), 0);
    send(10'h355, 6'd21, 1'b1, 1'b0, 1'b0);
    check("post_clear_corrcnt", int'(CorrCnt), 1);

    // Backpressure: first word parks in the output stage, the next two must wait
    send(10'h315, 6'd21, 1'b0, 1'b0, 1'b0);
    OutReady = 1'b0;
    streamDone = 1'b0;
    fork
      begin
        send(10'h368, 6'd40, 1'b0, 1'b0, 1'b0);
        send(10'h3A9, 6'd41, 1'b0, 1'b0, 1'b1);
        streamDone = 1'b1;
      end
    join_none
    repeat (4) begin
      @(negedge Clk);
      check("bp_inready", int'(InReady), 0);
      check("bp_outvalid", int'(OutValid), 1);
      check("bp_hold_addr", int'(ColAddr), 21);
    end
    @(posedge Clk); #1;
    OutReady = 1'b1;
    wait_cyc = 0;
    while (!streamDone && wait_cyc < 100) begin
      @(posedge Clk); #1;
      wait_cyc++;
    end
    check("bp_stream_done", int'(streamDone), 1);
    repeat (3) @(posedge Clk);
    #1;
    check("bp_queue_empty", expQ.size(), 0);
    check("total_popped", popped, 15);

    // Async reset while a word is held
    OutReady = 1'b0;
    send(10'h31D, 6'd21, 1'b1, 1'b0, 1'b0);
    @(negedge Clk);
    check("pre_rst_outvalid", int'(OutValid), 1);
    #2;
    Reset_b = 1'b0;
    #1;
    check("arst_outvalid", int'(OutValid), 0);
    check("arst_coladdr", int'(ColAddr), 0);
    check("arst_flags", int'({Corrected, Uncorrectable, RangeErr}), 0);
    check("arst_cnts", int'({CorrCnt, UncorrCnt}), 0);
    check("arst_inready", int'(InReady), 1);
    expQ.delete();
    @(posedge Clk); #1;
    Reset_b = 1'b1;
    OutReady = 1'b1;
    repeat (2) @(posedge Clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
